// File: rtl/tetris_pkg.sv
// tetris_pkg: block type codes, move direction codes, move-engine FSM states
// and the grid stride helper (one border column on each side of the playfield).
package tetris_pkg;

  localparam logic [3:0] BLOCK_AIR    = 4'd0;
  localparam logic [3:0] BLOCK_I      = 4'd1;
  localparam logic [3:0] BLOCK_O      = 4'd2;
  localparam logic [3:0] BLOCK_T      = 4'd3;
  localparam logic [3:0] BLOCK_S      = 4'd4;
  localparam logic [3:0] BLOCK_Z      = 4'd5;
  localparam logic [3:0] BLOCK_J      = 4'd6;
  localparam logic [3:0] BLOCK_L      = 4'd7;
  localparam logic [3:0] BLOCK_BORDER = 4'd8;

  localparam logic [1:0] MOVE_DOWN  = 2'd0;
  localparam logic [1:0] MOVE_LEFT  = 2'd1;
  localparam logic [1:0] MOVE_RIGHT = 2'd2;
  localparam logic [1:0] MOVE_DROP  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CK_ADDR = 3'd1,
    ST_CK_DATA = 3'd2,
    ST_ERASE   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic int stride_f(input int cols);
    return cols + 2;
  endfunction

endpackage

// File: rtl/piece_target_gen.sv
// piece_target_gen: combinational target addresses for a 4-cell move plus a mask
// of targets that land on a cell the piece already occupies.
module piece_target_gen
  import tetris_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [4*ADDR_W-1:0] i_pos,
  input  logic [1:0]          i_dir,
  input  logic [ADDR_W-1:0]   i_stride,
  output logic [4*ADDR_W-1:0] o_target,
  output logic [3:0]          o_overlap
);

  logic [ADDR_W-1:0] w_delta;

  always_comb begin
    w_delta   = i_stride;
    o_target  = '0;
    o_overlap = '0;
    case (i_dir)
      MOVE_LEFT:  w_delta = '1;  // all-ones is -1 modulo 2^ADDR_W
      MOVE_RIGHT: w_delta = ADDR_W'(1);
      default:    w_delta = i_stride;
    endcase
    for (int i = 0; i < 4; i++) begin
      o_target[i*ADDR_W +: ADDR_W] = i_pos[i*ADDR_W +: ADDR_W] + w_delta;
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (o_target[i*ADDR_W +: ADDR_W] == i_pos[j*ADDR_W +: ADDR_W]) o_overlap[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piece_move_engine.sv
// piece_move_engine: holds the active piece and runs check/erase/write moves on a
// 1-cycle-latency grid RAM. Macro PIECE_MOVE_ENGINE_HARD_DROP_EN enables hard drop.
module piece_move_engine
  import tetris_pkg::*;
#(
  parameter int GRID_COLS = 10,
  parameter int GRID_ROWS = 20,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*ADDR_W-1:0] pos_in,
  input  logic [3:0]          type_in,
  input  logic                move_req,
  input  logic [1:0]          move_dir,
  output logic                busy,
  output logic                done,
  output logic                collided,
  output logic [4*ADDR_W-1:0] pos_out,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
  output logic [ADDR_W-1:0]   rows_moved,
`endif
  output logic [2:0]          dbg_state
);

  localparam int STRIDE = stride_f(GRID_COLS);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  if ((GRID_ROWS + 1) * STRIDE > (1 << ADDR_W)) begin : g_addr_w_check
    $error("ADDR_W too small for grid");
  end

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_idx, w_idx_nxt;
  logic [4*ADDR_W-1:0] r_pos, w_pos_nxt, w_tgt_flat;
  logic [3:0]          r_type, w_type_nxt, w_ovl;
  logic [1:0]          r_dir, w_dir_nxt;
  logic                r_coll, w_coll_nxt;
  logic                w_hit, w_drop;
  logic [ADDR_W-1:0]   w_pos_arr [4];
  logic [ADDR_W-1:0]   w_tgt_arr [4];
  logic [DATA_W-1:0]   w_unused_rdata;
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
  logic [ADDR_W-1:0]   r_rows, w_rows_nxt;
  assign w_drop     = (r_dir == MOVE_DROP);
  assign rows_moved = r_rows;
`else
  assign w_drop = 1'b0;
`endif

  // Targets are derived from held positions, which stay frozen until WRITE(3).
  piece_target_gen #(.ADDR_W(ADDR_W)) u_target_gen (
    .i_pos     (r_pos),
    .i_dir     (r_dir),
    .i_stride  (STRIDE_A),
    .o_target  (w_tgt_flat),
    .o_overlap (w_ovl)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_pos_arr[i] = r_pos[i*ADDR_W +: ADDR_W];
      w_tgt_arr[i] = w_tgt_flat[i*ADDR_W +: ADDR_W];
    end
  end

  assign w_unused_rdata = mem_rdata;
  assign w_hit     = !w_ovl[r_idx] && (mem_rdata[3:0] != BLOCK_AIR);
  assign pos_out   = r_pos;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_pos   <= '0;
      r_type  <= '0;
      r_dir   <= MOVE_DOWN;
      r_coll  <= 1'b0;
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
      r_rows  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pos   <= w_pos_nxt;
      r_type  <= w_type_nxt;
      r_dir   <= w_dir_nxt;
      r_coll  <= w_coll_nxt;
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
      r_rows  <= w_rows_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pos_nxt   = r_pos;
    w_type_nxt  = r_type;
    w_dir_nxt   = r_dir;
    w_coll_nxt  = r_coll;
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
    w_rows_nxt  = r_rows;
`endif
    busy      = (r_state != ST_IDLE);
    done      = 1'b0;
    collided  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_pos_nxt  = pos_in;
          w_type_nxt = type_in;
        end else if (move_req) begin
          w_dir_nxt   = move_dir;
          w_idx_nxt   = '0;
          w_coll_nxt  = 1'b0;
          w_state_nxt = ST_CK_ADDR;
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
          w_rows_nxt  = '0;
`endif
        end
      end
      ST_CK_ADDR: begin
        mem_addr    = w_tgt_arr[r_idx];
        w_state_nxt = ST_CK_DATA;
      end
      ST_CK_DATA: begin
        mem_addr  = w_tgt_arr[r_idx];
        w_idx_nxt = r_idx + 2'd1;
        if (w_hit) w_coll_nxt = 1'b1;
        if (r_idx != 2'd3) begin
          w_state_nxt = ST_CK_ADDR;
        end else if (r_coll || w_hit) begin
          w_state_nxt = ST_DONE;
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
          // A drop that moved at least one row is a success, not a rejection.
          if (w_drop) w_coll_nxt = (r_rows == '0);
`endif
        end else begin
          w_state_nxt = ST_ERASE;
        end
      end
      ST_ERASE: begin
        mem_we    = 1'b1;
        mem_addr  = w_pos_arr[r_idx];
        w_idx_nxt = r_idx + 2'd1;
        if (r_idx == 2'd3) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = w_tgt_arr[r_idx];
        mem_wdata = {{(DATA_W-4){1'b0}}, r_type};
        w_idx_nxt = r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          w_pos_nxt = w_tgt_flat;
          if (w_drop) begin
            w_state_nxt = ST_CK_ADDR;
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
            w_rows_nxt  = r_rows + ADDR_W'(1);
`endif
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        collided    = r_coll;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_piece_move_engine.sv
// tb_piece_move_engine: directed and randomized moves against a grid RAM model,
// checked with a move-level reference model of the playfield.
module tb_piece_move_engine;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int S    = 12;

  logic          clk = 1'b0;
  logic          reset, load, move_req;
  logic [4*AW-1:0] pos_in, pos_out;
  logic [3:0]    type_in;
  logic [1:0]    move_dir;
  logic          busy, done, collided, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [2:0]    dbg_state;
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
  logic [AW-1:0] rows_moved;
`endif

  logic [DW-1:0] grid     [256];
  logic [DW-1:0] ref_grid [256];
  int            ref_pos  [4];
  logic [3:0]    ref_type;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            shape_off [5][4] = '{'{0, 1, S, S+1}, '{0, 1, 2, 3}, '{0, S, 2*S, 3*S},
                                      '{0, 1, 2, S+1}, '{1, 2, S, S+1}};

  piece_move_engine #(.GRID_COLS(COLS), .GRID_ROWS(ROWS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .load(load), .pos_in(pos_in), .type_in(type_in),
    .move_req(move_req), .move_dir(move_dir), .busy(busy), .done(done),
    .collided(collided), .pos_out(pos_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata),
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
    .rows_moved(rows_moved),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Single-port grid RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_we) grid[mem_addr] <= mem_wdata;
    mem_rdata <= grid[mem_addr];
  end

  // ---------------- reference model ----------------
  function automatic int delta_of(input int dir);
    case (dir)
      1:       return -1;
      2:       return 1;
      default: return S;
    endcase
  endfunction

  task automatic model_step(input int dir, output bit coll);
    int t [4];
    bit mine;
    coll = 1'b0;
    for (int i = 0; i < 4; i++) t[i] = (ref_pos[i] + delta_of(dir)) & 255;
    for (int i = 0; i < 4; i++) begin
      mine = 1'b0;
      for (int j = 0; j < 4; j++) if (t[i] == ref_pos[j]) mine = 1'b1;
      if (!mine && ref_grid[t[i]][3:0] != 4'd0) coll = 1'b1;
    end
    if (!coll) begin
      for (int i = 0; i < 4; i++) ref_grid[ref_pos[i]] = '0;
      for (int i = 0; i < 4; i++) ref_grid[t[i]] = {4'd0, ref_type};
      for (int i = 0; i < 4; i++) ref_pos[i] = t[i];
    end
  endtask

  function automatic logic [4*AW-1:0] exp_pos();
    return {AW'(ref_pos[3]), AW'(ref_pos[2]), AW'(ref_pos[1]), AW'(ref_pos[0])};
  endfunction

  function automatic int count_bad();
    int bad = 0;
    for (int a = 0; a < 256; a++) if (grid[a] !== ref_grid[a]) bad++;
    return bad;
  endfunction

  // ---------------- drivers ----------------
  task automatic init_grid();
    logic [DW-1:0] v;
    for (int a = 0; a < 256; a++) begin
      v = (a >= ROWS*S || a % S == 0 || a % S == S-1) ? DW'(8) : DW'(0);
      grid[a]     = v;
      ref_grid[a] = v;
    end
  endtask

  task automatic paint(input int a, input logic [DW-1:0] v);
    grid[a]     = v;
    ref_grid[a] = v;
  endtask

  task automatic do_load(input int p0, input int p1, input int p2, input int p3, input logic [3:0] t);
    @(negedge clk);
    load   = 1'b1;
    pos_in = {AW'(p3), AW'(p2), AW'(p1), AW'(p0)};
    type_in = t;
    @(negedge clk);
    load = 1'b0;
    ref_pos[0] = p0; ref_pos[1] = p1; ref_pos[2] = p2; ref_pos[3] = p3;
    ref_type = t;
  endtask

  task automatic place_piece(input int p0, input int p1, input int p2, input int p3, input logic [3:0] t);
    paint(p0, {4'd0, t}); paint(p1, {4'd0, t}); paint(p2, {4'd0, t}); paint(p3, {4'd0, t});
    do_load(p0, p1, p2, p3, t);
  endtask

  task automatic run_move(input logic [1:0] dir, input int budget, output int lat,
                          output int we_cnt, output bit coll_seen, output bit first_busy);
    lat = -1; we_cnt = 0; coll_seen = 1'b0; first_busy = 1'b0;
    @(negedge clk);
    move_req = 1'b1;
    move_dir = dir;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      move_req = 1'b0;
      if (n == 1) first_busy = busy;
      if (mem_we) we_cnt++;
      if (done) begin
        lat = n;
        coll_seen = collided;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; load = 1'b0; move_req = 1'b0; pos_in = '0; type_in = '0; move_dir = '0;
    init_grid();
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (collided !== 1'b0) begin n_fail++; $display("FAIL reset_collided got %b want 0", collided); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_we); end
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    n_tests++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got %0d want 0", mem_wdata); end
    n_tests++; if (pos_out !== '0) begin n_fail++; $display("FAIL reset_pos got %h want 0", pos_out); end
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || pos_out !== '0) begin
      n_fail++; $display("FAIL post_reset busy=%b pos=%h want 0/0", busy, pos_out); end
  endtask

  task automatic test_directed();
    int lat, wec; bit cs, fb, ec;
    // O piece falls one row, then again back-to-back
    init_grid();
    place_piece(5, 6, 17, 18, 4'd2);
    model_step(0, ec);
    run_move(2'd0, 40, lat, wec, cs, fb);
    n_tests++; if (lat !== 17) begin n_fail++; $display("FAIL d1_latency got %0d want 17", lat); end
    n_tests++; if (cs !== 1'b0) begin n_fail++; $display("FAIL d1_collided got %b want 0", cs); end
    n_tests++; if (fb !== 1'b1) begin n_fail++; $display("FAIL d1_busy_cycle1 got %b want 1", fb); end
    n_tests++; if (pos_out !== {8'd30, 8'd29, 8'd18, 8'd17}) begin
      n_fail++; $display("FAIL d1_pos got %h want 1e1d1211", pos_out); end
    n_tests++; if (grid[5] !== 8'd0 || grid[6] !== 8'd0 || grid[29] !== 8'd2 || grid[30] !== 8'd2) begin
      n_fail++; $display("FAIL d1_cells got %0d %0d %0d %0d want 0 0 2 2", grid[5], grid[6], grid[29], grid[30]); end
    n_tests++; if (count_bad() !== 0) begin n_fail++; $display("FAIL d1_grid got %0d bad cells want 0", count_bad()); end
    model_step(0, ec);
    run_move(2'd0, 40, lat, wec, cs, fb);
    n_tests++; if (lat !== 17 || pos_out !== exp_pos()) begin
      n_fail++; $display("FAIL d1b_back_to_back lat=%0d pos=%h want 17 %h", lat, pos_out, exp_pos()); end

    // I piece against the left wall
    init_grid();
    place_piece(13, 14, 15, 16, 4'd1);
    run_move(2'd1, 40, lat, wec, cs, fb);
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL d2_latency got %0d want 9", lat); end
    n_tests++; if (cs !== 1'b1) begin n_fail++; $display("FAIL d2_collided got %b want 1", cs); end
    n_tests++; if (wec !== 0) begin n_fail++; $display("FAIL d2_writes got %0d want 0", wec); end
    n_tests++; if (pos_out !== exp_pos()) begin n_fail++; $display("FAIL d2_pos got %h want %h", pos_out, exp_pos()); end

    // vertical I, only the lowest target is a real check
    init_grid();
    place_piece(6, 18, 30, 42, 4'd1);
    model_step(0, ec);
    run_move(2'd0, 40, lat, wec, cs, fb);
    n_tests++; if (lat !== 17 || cs !== 1'b0) begin
      n_fail++; $display("FAIL d3_move lat=%0d coll=%b want 17 0", lat, cs); end
    n_tests++; if (pos_out !== {8'd54, 8'd42, 8'd30, 8'd18}) begin
      n_fail++; $display("FAIL d3_pos got %h want 362a1e12", pos_out); end

    // blocked by a settled cell below
    init_grid();
    paint(29, 8'd5);
    place_piece(5, 6, 17, 18, 4'd3);
    run_move(2'd0, 40, lat, wec, cs, fb);
    n_tests++; if (lat !== 9 || cs !== 1'b1) begin
      n_fail++; $display("FAIL d4_move lat=%0d coll=%b want 9 1", lat, cs); end
    n_tests++; if (grid[29] !== 8'd5 || count_bad() !== 0) begin
      n_fail++; $display("FAIL d4_grid cell29=%0d bad=%0d want 5 0", grid[29], count_bad()); end
  endtask

  task automatic test_load_priority();
    bit busy_seen = 1'b0;
    @(negedge clk);
    load = 1'b1; move_req = 1'b1; move_dir = 2'd0;
    pos_in = {8'd103, 8'd102, 8'd101, 8'd100}; type_in = 4'd6;
    @(negedge clk);
    load = 1'b0; move_req = 1'b0;
    ref_pos[0] = 100; ref_pos[1] = 101; ref_pos[2] = 102; ref_pos[3] = 103; ref_type = 4'd6;
    for (int n = 0; n < 4; n++) begin
      if (busy !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL lp_busy got 1 want 0"); end
    n_tests++; if (pos_out !== exp_pos()) begin n_fail++; $display("FAIL lp_pos got %h want %h", pos_out, exp_pos()); end
  endtask

  task automatic test_busy_ignore();
    int lat = -1; bit ec; bit busy_seen = 1'b0;
    init_grid();
    place_piece(40, 41, 52, 53, 4'd4);
    model_step(2, ec);
    @(negedge clk);
    move_req = 1'b1; move_dir = 2'd2;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      move_req = 1'b0; load = 1'b0;
      if (done) begin lat = n; break; end
      if (n == 3) begin
        load = 1'b1; move_req = 1'b1; pos_in = {8'd99, 8'd98, 8'd97, 8'd96};
      end
    end
    n_tests++; if (lat !== 17) begin n_fail++; $display("FAIL bi_latency got %0d want 17", lat); end
    n_tests++; if (pos_out !== exp_pos()) begin n_fail++; $display("FAIL bi_pos got %h want %h", pos_out, exp_pos()); end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    n_tests++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL bi_no_queue got busy want idle"); end
  endtask

  task automatic test_reset_mid();
    init_grid();
    place_piece(5, 6, 17, 18, 4'd2);
    @(negedge clk);
    move_req = 1'b1; move_dir = 2'd0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      move_req = 1'b0;
    end
    n_tests++; if (mem_we !== 1'b1 || mem_addr !== 8'd6) begin
      n_fail++; $display("FAIL rm_erase1 we=%b addr=%0d want 1 6", mem_we, mem_addr); end
    reset = 1'b0;
    #1;
    n_tests++; if (mem_we !== 1'b0 || busy !== 1'b0 || pos_out !== '0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rm_async we=%b busy=%b pos=%h done=%b want 0 0 0 0", mem_we, busy, pos_out, done); end
    @(negedge clk);
    reset = 1'b1;
    init_grid();
    for (int i = 0; i < 4; i++) ref_pos[i] = 0;
    ref_type = 4'd0;
  endtask

  task automatic test_dir3();
    int lat, wec; bit cs, fb, ec; int rows;
    init_grid();
    place_piece(5, 6, 17, 18, 4'd2);
`ifdef PIECE_MOVE_ENGINE_HARD_DROP_EN
    rows = 0;
    ec = 1'b0;
    while (!ec) begin
      model_step(0, ec);
      if (!ec) rows++;
    end
    run_move(2'd3, 3000, lat, wec, cs, fb);
    n_tests++; if (lat < 0) begin n_fail++; $display("FAIL hd_timeout got no done want done"); end
    n_tests++; if (cs !== 1'b0) begin n_fail++; $display("FAIL hd_collided got %b want 0", cs); end
    n_tests++; if (rows_moved !== AW'(rows) || rows !== 18) begin
      n_fail++; $display("FAIL hd_rows got %0d want %0d (18)", rows_moved, rows); end
    n_tests++; if (pos_out !== {8'd234, 8'd233, 8'd222, 8'd221}) begin
      n_fail++; $display("FAIL hd_pos got %h want eae9dedd", pos_out); end
    n_tests++; if (count_bad() !== 0) begin n_fail++; $display("FAIL hd_grid got %0d bad cells want 0", count_bad()); end
`else
    rows = 0;
    model_step(0, ec);
    run_move(2'd3, 40, lat, wec, cs, fb);
    n_tests++; if (lat !== 17 || cs !== 1'b0 || rows !== 0) begin
      n_fail++; $display("FAIL d3r_move lat=%0d coll=%b want 17 0", lat, cs); end
    n_tests++; if (pos_out !== exp_pos() || count_bad() !== 0) begin
      n_fail++; $display("FAIL d3r_result pos=%h bad=%0d want %h 0", pos_out, count_bad(), exp_pos()); end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int sh, base, dir, lat, wec, exp_lat;
      bit cs, fb, ec;
      logic [3:0] t;
      init_grid();
      for (int k = 0; k < 8; k++)
        paint(int'($urandom_range(0, 19)) * S + int'($urandom_range(1, 10)), DW'($urandom_range(1, 7)));
      sh   = int'($urandom_range(0, 4));
      base = int'($urandom_range(0, 16)) * S + int'($urandom_range(1, 7));
      t    = 4'($urandom_range(1, 7));
      place_piece(base + shape_off[sh][0], base + shape_off[sh][1],
                  base + shape_off[sh][2], base + shape_off[sh][3], t);
      dir = int'($urandom_range(0, 2));
      model_step(dir, ec);
      exp_lat = ec ? 9 : 17;
      run_move(2'(dir), 40, lat, wec, cs, fb);
      n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", it, lat, exp_lat); end
      n_tests++; if (cs !== ec) begin n_fail++; $display("FAIL rnd%0d_collided got %b want %b", it, cs, ec); end
      n_tests++; if (pos_out !== exp_pos()) begin n_fail++; $display("FAIL rnd%0d_pos got %h want %h", it, pos_out, exp_pos()); end
      n_tests++; if (wec !== (ec ? 0 : 8)) begin n_fail++; $display("FAIL rnd%0d_writes got %0d want %0d", it, wec, ec ? 0 : 8); end
      n_tests++; if (count_bad() !== 0) begin n_fail++; $display("FAIL rnd%0d_grid got %0d bad cells want 0", it, count_bad()); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_load_priority();
    test_busy_ignore();
    test_reset_mid();
    test_dir3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
